// File: rtl/stream_pattern_detector_if.sv
// Framed one-bit stream into the detector and flagged beats out of it.
interface stream_pattern_detector_if #(
  parameter int CNT_W = 8
);
  logic             inp;
  logic             i_valid;
  logic             i_sop;
  logic             i_eop;
  logic             i_ready;
  logic             o_ready;
  logic             outp;
  logic             o_valid;
  logic             o_sop;
  logic             o_eop;
  logic [CNT_W-1:0] o_count;
  logic             o_err;

  modport slave (
    input  inp, i_valid, i_sop, i_eop, o_ready,
    output i_ready, outp, o_valid, o_sop, o_eop,
    output o_count, o_err
  );

  modport master (
    output inp, i_valid, i_sop, i_eop, o_ready,
    input  i_ready, outp, o_valid, o_sop, o_eop,
    input  o_count, o_err
  );
endinterface

// File: rtl/stream_pattern_detector.sv
// Programmable pattern detector on a framed 1-bit stream,
// with per-packet match count and a 2-entry output buffer.
module stream_pattern_detector #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8
) (
  input logic clk,
  input logic reset_n,
  stream_pattern_detector_if.slave bus
);
  localparam int FW = $clog2(PAT_LEN);
  localparam logic [FW-1:0] FULL = FW'(PAT_LEN - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef enum logic {IDLE, IN_PKT} state_t;

  typedef struct packed {
    logic             m;
    logic             sop;
    logic             eop;
    logic [CNT_W-1:0] cnt;
  } beat_t;

  state_t             state_q, state_d;
  logic [PAT_LEN-2:0] hist_q, hist_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  beat_t              head_q, tail_q, nb;
  logic [1:0]         occ_q;
  logic               acc, pop, fwd, match, vld;
  logic [PAT_LEN-1:0] win;

  assign bus.i_ready = reset_n && (occ_q != 2'd2);
  assign acc = bus.i_valid && bus.i_ready;
  assign vld = (occ_q != 2'd0);
  assign pop = vld && bus.o_ready;
  assign win = {hist_q, bus.inp};

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    fwd     = 1'b0;
    match   = 1'b0;
    nb      = '0;
    if (acc) begin
      unique case (1'b1)
        bus.i_sop: begin
          // sop always restarts, even one that aborts a packet
          err_d     = (state_q == IN_PKT);
          fwd       = 1'b1;
          hist_d    = '0;
          hist_d[0] = bus.inp;
          fill_d    = FW'(1);
          cnt_d     = '0;
          state_d   = bus.i_eop ? IDLE : IN_PKT;
        end
        !bus.i_sop && state_q == IDLE: begin
          err_d = 1'b1;
        end
        !bus.i_sop && state_q == IN_PKT: begin
          fwd    = 1'b1;
          match  = (fill_q == FULL) && (win == PATTERN);
          hist_d = win[PAT_LEN-2:0];
          if (match) begin
            if (cnt_q != CMAX) cnt_d = cnt_q + 1'b1;
            if (!OVERLAP) fill_d = '0;
          end else if (fill_q != FULL) begin
            fill_d = fill_q + 1'b1;
          end
          if (bus.i_eop) state_d = IDLE;
        end
      endcase
      nb.m   = match;
      nb.sop = bus.i_sop;
      nb.eop = bus.i_eop;
      nb.cnt = bus.i_eop ? cnt_d : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (pop && occ_q == 2'd2) head_q <= tail_q;
      if (fwd) begin
        if (occ_q == 2'd0 || (occ_q == 2'd1 && pop)) head_q <= nb;
        else tail_q <= nb;
      end
      occ_q <= occ_q + {1'b0, fwd} - {1'b0, pop};
    end
  end

  assign bus.o_valid = vld;
  assign bus.outp    = vld && head_q.m;
  assign bus.o_sop   = vld && head_q.sop;
  assign bus.o_eop   = vld && head_q.eop;
  assign bus.o_count = vld ? head_q.cnt : '0;
  assign bus.o_err   = err_q;
endmodule

// File: tb/tb_stream_pattern_detector.sv
// Bench: three detector configurations driven by one stream,
// each checked against a window-based reference model.
module tb_stream_pattern_detector;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic b = 1'b0, v = 1'b0, sp = 1'b0, ep = 1'b0, r = 1'b1;

  always #5 clk = ~clk;

  stream_pattern_detector_if s0 ();
  stream_pattern_detector_if s1 ();
  stream_pattern_detector_if #(.CNT_W(2)) s2 ();

  stream_pattern_detector d0 (.clk(clk), .reset_n(reset_n), .bus(s0));
  stream_pattern_detector #(.OVERLAP(1'b0)) d1 (
    .clk(clk), .reset_n(reset_n), .bus(s1));
  stream_pattern_detector #(
    .PAT_LEN(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(2)
  ) d2 (.clk(clk), .reset_n(reset_n), .bus(s2));

  assign {s0.inp, s0.i_valid, s0.i_sop, s0.i_eop, s0.o_ready} = {b, v, sp, ep, r};
  assign {s1.inp, s1.i_valid, s1.i_sop, s1.i_eop, s1.o_ready} = {b, v, sp, ep, r};
  assign {s2.inp, s2.i_valid, s2.i_sop, s2.i_eop, s2.o_ready} = {b, v, sp, ep, r};

  logic       ir[3], ov[3], op[3], osp[3], oep[3], oer[3];
  logic [7:0] oc[3];
  assign {ir[0], ov[0], op[0], osp[0], oep[0], oer[0]} =
    {s0.i_ready, s0.o_valid, s0.outp, s0.o_sop, s0.o_eop, s0.o_err};
  assign {ir[1], ov[1], op[1], osp[1], oep[1], oer[1]} =
    {s1.i_ready, s1.o_valid, s1.outp, s1.o_sop, s1.o_eop, s1.o_err};
  assign {ir[2], ov[2], op[2], osp[2], oep[2], oer[2]} =
    {s2.i_ready, s2.o_valid, s2.outp, s2.o_sop, s2.o_eop, s2.o_err};
  assign oc[0] = s0.o_count;
  assign oc[1] = s1.o_count;
  assign oc[2] = {6'd0, s2.o_count};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // reference model: pattern config per instance
  int L[3]  = '{4, 4, 2};
  int P[3]  = '{11, 11, 3};
  bit OV[3] = '{1'b1, 1'b0, 1'b1};
  int CM[3] = '{255, 255, 3};

  typedef struct {
    bit m;
    bit s;
    bit e;
    int c;
  } ent_t;

  int   recent[3], nbits[3], cnt[3], occ[3];
  bit   in_pkt[3], errq[3];
  ent_t fq[3][2];
  bit   acc_last;
  int   last_cnt[3], seq[3];

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      recent[k] = 0; nbits[k] = 0; cnt[k] = 0; occ[k] = 0;
      in_pkt[k] = 0; errq[k] = 0;
    end
    acc_last = 0;
  endtask

  task automatic update(int k);
    bit acc, pop, nerr, fwd, m;
    ent_t ne;
    acc = v && occ[k] != 2;
    pop = occ[k] != 0 && r;
    nerr = 0; fwd = 0; m = 0;
    if (acc && sp) begin
      nerr = in_pkt[k];
      recent[k] = int'(b); nbits[k] = 1; cnt[k] = 0;
      fwd = 1; in_pkt[k] = !ep;
    end else if (acc && !in_pkt[k]) begin
      nerr = 1;
    end else if (acc) begin
      recent[k] = ((recent[k] << 1) | int'(b)) & 'hffff;
      nbits[k]++;
      m = nbits[k] >= L[k] && (recent[k] & ((1 << L[k]) - 1)) == P[k];
      if (m) begin
        cnt[k] = (cnt[k] < CM[k]) ? cnt[k] + 1 : CM[k];
        if (!OV[k]) nbits[k] = 0;
      end
      fwd = 1;
      if (ep) in_pkt[k] = 0;
    end
    ne.m = m; ne.s = sp; ne.e = ep; ne.c = ep ? cnt[k] : 0;
    if (pop) begin fq[k][0] = fq[k][1]; occ[k]--; end
    if (fwd) begin fq[k][occ[k]] = ne; occ[k]++; end
    errq[k] = nerr;
    if (k == 0) acc_last = acc;
  endtask

  task automatic check_one(int k);
    ent_t h;
    h = fq[k][0];
    if (occ[k] == 0) begin h.m = 0; h.s = 0; h.e = 0; h.c = 0; end
    check($sformatf("d%0d i_ready", k), ir[k], reset_n && occ[k] != 2);
    check($sformatf("d%0d o_valid", k), ov[k], occ[k] != 0);
    check($sformatf("d%0d outp", k), op[k], h.m);
    check($sformatf("d%0d o_sop", k), osp[k], h.s);
    check($sformatf("d%0d o_eop", k), oep[k], h.e);
    check($sformatf("d%0d o_count", k), oc[k], h.c);
    check($sformatf("d%0d o_err", k), oer[k], errq[k]);
    if (ov[k] && r) seq[k] = (seq[k] << 1) | int'(op[k]);
    if (ov[k] && oep[k]) last_cnt[k] = int'(oc[k]);
  endtask

  task automatic cycle();
    @(posedge clk);
    acc_last = 0;
    if (reset_n) for (int k = 0; k < 3; k++) update(k);
    @(negedge clk);
    for (int k = 0; k < 3; k++) check_one(k);
  endtask

  task automatic beat(logic bi, logic si, logic ei);
    int t = 0;
    b = bi; sp = si; ep = ei; v = 1'b1;
    do begin cycle(); t++; end while (!acc_last && t < 20);
    if (!acc_last) check("beat timeout", 0, 1);
    v = 1'b0; sp = 1'b0; ep = 1'b0;
  endtask

  task automatic pkt(logic [15:0] bits, int len, bit with_eop);
    for (int i = 0; i < len; i++)
      beat(bits[len-1-i], i == 0, with_eop && i == len - 1);
  endtask

  task automatic idle(int n);
    v = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic clr_seq();
    for (int k = 0; k < 3; k++) seq[k] = 0;
  endtask

  initial begin
    int na;
    model_reset();
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) check_one(k);
    reset_n = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) check_one(k);

    // overlap / non-overlap on 1,0,1,1,0,1,1
    r = 1'b1; clr_seq();
    pkt(16'b1011011, 7, 1);
    idle(3);
    check("overlap seq", seq[0], 32'b0001001);
    check("nonoverlap seq", seq[1], 32'b0001000);
    check("overlap count", last_cnt[0], 2);
    check("nonoverlap count", last_cnt[1], 1);
    check("pat11 count", last_cnt[2], 2);

    // beat without sop in IDLE
    b = 1'b1; sp = 1'b0; ep = 1'b0; v = 1'b1;
    cycle();
    v = 1'b0;
    check("drop err", oer[0], 1);
    check("drop valid", ov[0], 0);
    cycle();
    check("err width", oer[0], 0);

    // sop mid-packet restarts; no match across boundary
    pkt(16'b101, 3, 0);
    pkt(16'b1011, 4, 1);
    idle(3);
    check("restart count d0", last_cnt[0], 1);
    check("restart count d1", last_cnt[1], 1);

    // saturation of 2-bit counter
    pkt(16'h3f, 6, 1);
    idle(3);
    check("sat count d2", last_cnt[2], 3);
    check("sat count d0", last_cnt[0], 0);

    // backpressure
    r = 1'b0; v = 1'b1; sp = 1'b1; ep = 1'b0; b = 1'b1;
    na = 0;
    repeat (4) begin
      cycle();
      if (acc_last) begin na++; sp = 1'b0; b = 1'($urandom); end
    end
    check("bp accepts", na, 2);
    check("bp i_ready", ir[0], 0);
    r = 1'b1;
    for (int i = 0; i < 4; i++) beat(1'($urandom), 1'b0, i == 3);
    idle(4);

    // reset with two entries buffered
    r = 1'b0;
    beat(1'b1, 1'b1, 1'b0);
    beat(1'b0, 1'b0, 1'b0);
    check("pre-reset full", ir[0], 0);
    reset_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) check_one(k);
    cycle();
    reset_n = 1'b1; r = 1'b1; clr_seq();
    pkt(16'b1011, 4, 1);
    idle(3);
    check("post-reset seq", seq[0], 32'b0001);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      v  = $urandom_range(0, 3) != 0;
      b  = 1'($urandom);
      sp = $urandom_range(0, 6) == 0;
      ep = $urandom_range(0, 4) == 0;
      r  = $urandom_range(0, 3) != 0;
      cycle();
    end
    v = 1'b0; r = 1'b1;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
